demux1to4b4_reg: RTL and testbench

Registered 1-to-4 demultiplexer for 4-bit words: the receiving end of the 4-to-1 mux path. A single input stream with valid/ready handshake is steered by a 2-bit select `s` into one of four output holding registers, or into all four in broadcast mode. Each output channel has its own valid/ready handshake and an accepted-word counter. The block sits downstream of `Mux4to14b`-style source selection and fans a shared bus back out to four consumers.

---
 rtl/demux1to4b4_reg_if.sv | 38 +++
 rtl/demux1to4b4_reg.sv | 83 ++++++++
 tb/tb_demux1to4b4_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/demux1to4b4_reg_if.sv
// Bus bundle for the registered 1-to-4 demux: one input stream fanned out to
// four held output channels, each with its own consumer handshake.
interface demux1to4b4_reg_if #(
    parameter int W  = 4,
    parameter int CW = 8
);
    // Handshake: a word moves on a rising edge exactly when valid and ready are
    // both 1; ready never depends on valid, and a source that sees valid=1 and
    // ready=0 keeps its payload (I, s, bcast) stable until the transfer.
    logic [1:0]    s;
    logic          bcast;
    logic [W-1:0]  I;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  o0;
    logic [W-1:0]  o1;
    logic [W-1:0]  o2;
    logic [W-1:0]  o3;
    logic [3:0]    o_valid;
    logic [3:0]    o_ready;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic [CW-1:0] cnt3;
    logic [3:0]    ch_full_dbg;

    modport master (
        output s, bcast, I, i_valid, o_ready,
        input  i_ready, o0, o1, o2, o3, o_valid,
        input  cnt0, cnt1, cnt2, cnt3, ch_full_dbg
    );

    modport slave (
        input  s, bcast, I, i_valid, o_ready,
        output i_ready, o0, o1, o2, o3, o_valid,
        output cnt0, cnt1, cnt2, cnt3, ch_full_dbg
    );
endinterface

// File: rtl/demux1to4b4_reg.sv
// Registered 1-to-4 demux: steers each accepted word into one channel (or all
// four in broadcast) and holds it until that channel's consumer takes it.
module demux1to4b4_reg #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input logic              clk,
    input logic              rst_n,
    demux1to4b4_reg_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e     state_q [4];
    logic [W-1:0]  data_q  [4];
    logic [CW-1:0] cnt_q   [4];
    logic [3:0]    full;
    logic [3:0]    free;
    logic [3:0]    wr;
    logic          accept;

    always_comb begin
        full = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            full[k] = (state_q[k] == FULL);
        end
    end

    // A channel can take a new word if it is empty or is being drained this cycle.
    assign free        = ~full | bus.o_ready;
    assign bus.i_ready = bus.bcast ? (&free) : free[bus.s];
    assign accept      = bus.i_valid & bus.i_ready;

    always_comb begin
        wr = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr[k] = accept & (bus.bcast | (bus.s == 2'(k)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (state_q[k])
                    EMPTY: begin
                        if (wr[k]) begin
                            state_q[k] <= FULL;
                        end
                    end
                    FULL: begin
                        if (!wr[k] && bus.o_ready[k]) begin
                            state_q[k] <= EMPTY;
                        end
                    end
                    default: state_q[k] <= EMPTY;
                endcase
                if (wr[k]) begin
                    data_q[k] <= bus.I;
                    cnt_q[k]  <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign bus.o_valid     = full;
    assign bus.ch_full_dbg = full;
    assign bus.o0          = data_q[0];
    assign bus.o1          = data_q[1];
    assign bus.o2          = data_q[2];
    assign bus.o3          = data_q[3];
    assign bus.cnt0        = cnt_q[0];
    assign bus.cnt1        = cnt_q[1];
    assign bus.cnt2        = cnt_q[2];
    assign bus.cnt3        = cnt_q[3];
endmodule

// File: tb/tb_demux1to4b4_reg.sv
// Directed bench for demux1to4b4_reg: reset, routing, backpressure, broadcast,
// pass-through and counter wrap, each with hand-computed expectations.
module tb_demux1to4b4_reg;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    demux1to4b4_reg_if #(.W(4), .CW(8)) bus_if ();

    demux1to4b4_reg #(.W(4), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        check({tag, " cnt0"}, 32'(bus_if.cnt0), 32'(c0));
        check({tag, " cnt1"}, 32'(bus_if.cnt1), 32'(c1));
        check({tag, " cnt2"}, 32'(bus_if.cnt2), 32'(c2));
        check({tag, " cnt3"}, 32'(bus_if.cnt3), 32'(c3));
    endtask

    task automatic check_data(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        check({tag, " o0"}, 32'(bus_if.o0), 32'(d0));
        check({tag, " o1"}, 32'(bus_if.o1), 32'(d1));
        check({tag, " o2"}, 32'(bus_if.o2), 32'(d2));
        check({tag, " o3"}, 32'(bus_if.o3), 32'(d3));
    endtask

    // Drive at the falling edge so inputs are settled well before the active edge.
    task automatic drive(input logic vld, input logic [1:0] sel, input logic bc,
                         input logic [3:0] data, input logic [3:0] rdy);
        @(negedge clk);
        bus_if.i_valid = vld;
        bus_if.s       = sel;
        bus_if.bcast   = bc;
        bus_if.I       = data;
        bus_if.o_ready = rdy;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus_if.i_valid = 1'b0;
        bus_if.s       = 2'd0;
        bus_if.bcast   = 1'b0;
        bus_if.I       = 4'h0;
        bus_if.o_ready = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst o_valid", 32'(bus_if.o_valid), 32'h0);
        check("rst i_ready", 32'(bus_if.i_ready), 32'h1);
        check("rst dbg", 32'(bus_if.ch_full_dbg), 32'h0);
        check_data("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        check_cnts("rst", 8'd0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Routing sweep: every consumer ready, one word per channel
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 1'b0, 4'(i), 4'hF);
            check($sformatf("sweep%0d i_ready", i), 32'(bus_if.i_ready), 32'h1);
            after_edge();
            check($sformatf("sweep%0d o_valid", i), 32'(bus_if.o_valid), 32'(4'b0001 << i));
        end
        drive(1'b0, 2'd0, 1'b0, 4'h0, 4'hF);
        after_edge();
        check("sweep drained", 32'(bus_if.o_valid), 32'h0);
        check_data("sweep", 4'h0, 4'h1, 4'h2, 4'h3);
        check_cnts("sweep", 8'd1, 8'd1, 8'd1, 8'd1);

        // Backpressure on channel 2
        drive(1'b1, 2'd2, 1'b0, 4'hA, 4'h0);
        check("bp first i_ready", 32'(bus_if.i_ready), 32'h1);
        after_edge();
        check("bp o2 A", 32'(bus_if.o2), 32'hA);
        check("bp o_valid", 32'(bus_if.o_valid), 32'b0100);
        drive(1'b1, 2'd2, 1'b0, 4'hB, 4'h0);
        check("bp stalled i_ready", 32'(bus_if.i_ready), 32'h0);
        after_edge();
        check("bp o2 held", 32'(bus_if.o2), 32'hA);
        check("bp cnt2 held", 32'(bus_if.cnt2), 32'd2);
        drive(1'b1, 2'd2, 1'b0, 4'hB, 4'b0100);
        check("bp release i_ready", 32'(bus_if.i_ready), 32'h1);
        after_edge();
        check("bp o2 B", 32'(bus_if.o2), 32'hB);
        check("bp o_valid stays", 32'(bus_if.o_valid), 32'b0100);
        check("bp cnt2", 32'(bus_if.cnt2), 32'd3);
        drive(1'b0, 2'd2, 1'b0, 4'h0, 4'b0100);
        after_edge();
        check("bp drained", 32'(bus_if.o_valid), 32'h0);

        // Broadcast blocked by full channel 1, then released
        drive(1'b1, 2'd1, 1'b0, 4'h7, 4'h0);
        after_edge();
        check("bc ch1 full", 32'(bus_if.o_valid), 32'b0010);
        drive(1'b1, 2'd0, 1'b1, 4'h5, 4'h0);
        check("bc blocked i_ready", 32'(bus_if.i_ready), 32'h0);
        after_edge();
        check_data("bc blocked", 4'h0, 4'h7, 4'hB, 4'h3);
        check_cnts("bc blocked", 8'd1, 8'd2, 8'd3, 8'd1);
        drive(1'b1, 2'd0, 1'b1, 4'h5, 4'b0010);
        check("bc open i_ready", 32'(bus_if.i_ready), 32'h1);
        after_edge();
        check("bc o_valid", 32'(bus_if.o_valid), 32'hF);
        check_data("bc", 4'h5, 4'h5, 4'h5, 4'h5);
        check_cnts("bc", 8'd2, 8'd3, 8'd4, 8'd2);

        // Asynchronous reset mid-stream, checked before the next rising edge
        drive(1'b1, 2'd0, 1'b0, 4'h9, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst o_valid", 32'(bus_if.o_valid), 32'h0);
        check("arst i_ready", 32'(bus_if.i_ready), 32'h1);
        check_data("arst", 4'h0, 4'h0, 4'h0, 4'h0);
        check_cnts("arst", 8'd0, 8'd0, 8'd0, 8'd0);
        after_edge();
        check("arst held o_valid", 32'(bus_if.o_valid), 32'h0);
        check("arst held cnt0", 32'(bus_if.cnt0), 32'd0);
        @(negedge clk);
        bus_if.i_valid = 1'b0;
        rst_n          = 1'b1;

        // Pass-through: 10 back-to-back words into channel 3
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 2'd3, 1'b0, 4'(j), 4'b1000);
            check($sformatf("pt%0d i_ready", j), 32'(bus_if.i_ready), 32'h1);
            after_edge();
            check($sformatf("pt%0d o3", j), 32'(bus_if.o3), 32'(j));
            check($sformatf("pt%0d o_valid", j), 32'(bus_if.o_valid), 32'b1000);
        end
        drive(1'b0, 2'd3, 1'b0, 4'h0, 4'b1000);
        after_edge();
        check("pt drained", 32'(bus_if.o_valid), 32'h0);
        check_cnts("pt", 8'd0, 8'd0, 8'd0, 8'd10);

        // Counter wrap on channel 0
        drive(1'b1, 2'd0, 1'b0, 4'hC, 4'b0001);
        repeat (255) @(posedge clk);
        #1;
        check("wrap cnt0 255", 32'(bus_if.cnt0), 32'd255);
        after_edge();
        check("wrap o0", 32'(bus_if.o0), 32'hC);
        check_cnts("wrap", 8'd0, 8'd0, 8'd0, 8'd10);
        drive(1'b0, 2'd0, 1'b0, 4'h0, 4'b0001);
        after_edge();
        check("wrap drained", 32'(bus_if.o_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
